id_ex_stage: RTL and testbench

Decode-to-execute pipeline register of the 5-stage RV32I core, sitting directly upstream of the ALU. It captures one decoded instruction per valid/ready handshake and resolves its register operands through EX/MEM and MEM/WB forwarding. It selects the ALU operand sources and detects load-use hazards by inserting a single bubble. Outputs feed the ALU operand/control inputs and the EX/MEM register.

---
 rtl/id_ex_stage_if.sv | 60 ++++++
 rtl/id_ex_stage.sv | 129 ++++++++++++
 tb/tb_id_ex_stage.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: the decoded instruction offered by ID and the
// operand/control bundle presented to EX, each with its own valid/ready pair.
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [RA_W-1:0] id_rs1_addr;
  logic [RA_W-1:0] id_rs2_addr;
  logic [RA_W-1:0] id_rd_addr;
  logic [3:0]      id_alu_op;
  logic [2:0]      id_funct3;
  logic            id_funct7_bit5;
  logic            id_use_pc;
  logic            id_use_imm;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_operand_a;
  logic [XLEN-1:0] ex_operand_b;
  logic [XLEN-1:0] ex_store_data;
  logic [XLEN-1:0] ex_pc;
  logic [3:0]      ex_alu_op;
  logic [2:0]      ex_funct3;
  logic            ex_funct7_bit5;
  logic [RA_W-1:0] ex_rd_addr;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;

  // Environment view: drives decode fields and the execute-side ready.
  modport master (
    output id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op, id_funct3,
           id_funct7_bit5, id_use_pc, id_use_imm, id_reg_write,
           id_mem_read, id_mem_write, ex_ready,
    input  id_ready, ex_valid, ex_operand_a, ex_operand_b, ex_store_data,
           ex_pc, ex_alu_op, ex_funct3, ex_funct7_bit5, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write
  );

  // Pipeline register view.
  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op, id_funct3,
           id_funct7_bit5, id_use_pc, id_use_imm, id_reg_write,
           id_mem_read, id_mem_write, ex_ready,
    output id_ready, ex_valid, ex_operand_a, ex_operand_b, ex_store_data,
           ex_pc, ex_alu_op, ex_funct3, ex_funct7_bit5, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds one decoded instruction, forwards EX/MEM and
// MEM/WB results into its operands and stalls one cycle on a load-use hazard.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  id_ex_stage_if.slave    bus,
  input  logic            flush,
  input  logic            mem_fwd_valid,
  input  logic [RA_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_valid,
  input  logic [RA_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data
);

  logic            ex_valid_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] imm_reg;
  logic [RA_W-1:0] rd_reg;
  logic [3:0]      alu_op_reg;
  logic [2:0]      funct3_reg;
  logic            funct7_bit5_reg;
  logic            use_pc_reg;
  logic            use_imm_reg;
  logic            reg_write_reg;
  logic            mem_read_reg;
  logic            mem_write_reg;

  logic            hazard;
  logic            accept;
  logic            release_w;
  logic            hold_w;

  logic [1:0][RA_W-1:0] id_rs_addr;
  logic [1:0][XLEN-1:0] id_rs_data;
  logic [1:0][XLEN-1:0] fwd_rs;

  // Conservative: a load in EX stalls any instruction naming its rd, used or not.
  assign hazard = ex_valid_reg & mem_read_reg & (rd_reg != '0) &
                  ((rd_reg == bus.id_rs1_addr) | (rd_reg == bus.id_rs2_addr));

  assign bus.id_ready = flush | ((~ex_valid_reg | bus.ex_ready) & ~hazard);
  assign accept       = bus.id_valid & bus.id_ready;
  assign release_w    = ex_valid_reg & bus.ex_ready;
  assign hold_w       = ex_valid_reg & ~bus.ex_ready & ~flush & ~accept;

  assign id_rs_addr = {bus.id_rs2_addr, bus.id_rs1_addr};
  assign id_rs_data = {bus.id_rs2_data, bus.id_rs1_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg    <= 1'b0;
      pc_reg          <= '0;
      imm_reg         <= '0;
      rd_reg          <= '0;
      alu_op_reg      <= '0;
      funct3_reg      <= '0;
      funct7_bit5_reg <= 1'b0;
      use_pc_reg      <= 1'b0;
      use_imm_reg     <= 1'b0;
      reg_write_reg   <= 1'b0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
    end else if (flush) begin
      ex_valid_reg <= 1'b0;
    end else if (accept) begin
      ex_valid_reg    <= 1'b1;
      pc_reg          <= bus.id_pc;
      imm_reg         <= bus.id_imm;
      rd_reg          <= bus.id_rd_addr;
      alu_op_reg      <= bus.id_alu_op;
      funct3_reg      <= bus.id_funct3;
      funct7_bit5_reg <= bus.id_funct7_bit5;
      use_pc_reg      <= bus.id_use_pc;
      use_imm_reg     <= bus.id_use_imm;
      reg_write_reg   <= bus.id_reg_write;
      mem_read_reg    <= bus.id_mem_read;
      mem_write_reg   <= bus.id_mem_write;
    end else if (release_w) begin
      ex_valid_reg <= 1'b0;
    end
  end

  // One slice per source operand: stored address/data plus its forwarding mux.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rs
      logic [RA_W-1:0] addr_reg;
      logic [XLEN-1:0] data_reg;
      logic            mem_hit;
      logic            wb_hit;

      assign mem_hit = mem_fwd_valid & (mem_fwd_rd == addr_reg) & (addr_reg != '0);
      assign wb_hit  = wb_fwd_valid  & (wb_fwd_rd  == addr_reg) & (addr_reg != '0);
      assign fwd_rs[gi] = mem_hit ? mem_fwd_data :
                          wb_hit  ? wb_fwd_data  : data_reg;

      // A stalled instruction latches WB results so they survive retirement.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          addr_reg <= '0;
          data_reg <= '0;
        end else if (!flush && accept) begin
          addr_reg <= id_rs_addr[gi];
          data_reg <= id_rs_data[gi];
        end else if (hold_w && wb_hit) begin
          data_reg <= wb_fwd_data;
        end
      end
    end
  endgenerate

  assign bus.ex_valid       = ex_valid_reg;
  assign bus.ex_operand_a   = use_pc_reg  ? pc_reg  : fwd_rs[0];
  assign bus.ex_operand_b   = use_imm_reg ? imm_reg : fwd_rs[1];
  assign bus.ex_store_data  = fwd_rs[1];
  assign bus.ex_pc          = pc_reg;
  assign bus.ex_alu_op      = alu_op_reg;
  assign bus.ex_funct3      = funct3_reg;
  assign bus.ex_funct7_bit5 = funct7_bit5_reg;
  assign bus.ex_rd_addr     = rd_reg;
  assign bus.ex_reg_write   = reg_write_reg;
  assign bus.ex_mem_read    = mem_read_reg;
  assign bus.ex_mem_write   = mem_write_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations, then
// random traffic compared every cycle against a transaction-level model.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush;
  logic mem_fwd_valid, wb_fwd_valid;
  logic [RA_W-1:0] mem_fwd_rd, wb_fwd_rd;
  logic [XLEN-1:0] mem_fwd_data, wb_fwd_data;

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, imm, rs1_data, rs2_data;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic [2:0]  f3;
    logic        f7, use_pc, use_imm, rw, mr, mw;
  } instr_t;

  instr_t m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] stored);
    if (a == 0) return stored;
    if (mem_fwd_valid && mem_fwd_rd == a) return mem_fwd_data;
    if (wb_fwd_valid && wb_fwd_rd == a) return wb_fwd_data;
    return stored;
  endfunction

  function automatic logic model_ready();
    logic load_use;
    load_use = m.valid && m.mr && m.rd != 0 &&
               (m.rd == bus.id_rs1_addr || m.rd == bus.id_rs2_addr);
    return flush || ((!m.valid || bus.ex_ready) && !load_use);
  endfunction

  function automatic instr_t offered();
    instr_t t;
    t.valid = 1'b1;
    t.pc = bus.id_pc; t.imm = bus.id_imm;
    t.rs1_data = bus.id_rs1_data; t.rs2_data = bus.id_rs2_data;
    t.rs1 = bus.id_rs1_addr; t.rs2 = bus.id_rs2_addr; t.rd = bus.id_rd_addr;
    t.alu_op = bus.id_alu_op; t.f3 = bus.id_funct3; t.f7 = bus.id_funct7_bit5;
    t.use_pc = bus.id_use_pc; t.use_imm = bus.id_use_imm;
    t.rw = bus.id_reg_write; t.mr = bus.id_mem_read; t.mw = bus.id_mem_write;
    return t;
  endfunction

  // Reference state: what instruction occupies the stage after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m = '{default: '0};
    end else if (flush) begin
      m.valid = 1'b0;
    end else if (bus.id_valid && model_ready()) begin
      m = offered();
    end else if (m.valid && bus.ex_ready) begin
      m.valid = 1'b0;
    end else if (m.valid && wb_fwd_valid && wb_fwd_rd != 0) begin
      if (wb_fwd_rd == m.rs1) m.rs1_data = wb_fwd_data;
      if (wb_fwd_rd == m.rs2) m.rs2_data = wb_fwd_data;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("id_ready", bus.id_ready, model_ready());
      chk("ex_valid", bus.ex_valid, m.valid);
      chk("ex_operand_a", bus.ex_operand_a, m.use_pc ? m.pc : fwd(m.rs1, m.rs1_data));
      chk("ex_operand_b", bus.ex_operand_b, m.use_imm ? m.imm : fwd(m.rs2, m.rs2_data));
      chk("ex_store_data", bus.ex_store_data, fwd(m.rs2, m.rs2_data));
      chk("ex_pc", bus.ex_pc, m.pc);
      chk("ex_alu_op", bus.ex_alu_op, m.alu_op);
      chk("ex_funct3", bus.ex_funct3, m.f3);
      chk("ex_funct7_bit5", bus.ex_funct7_bit5, m.f7);
      chk("ex_rd_addr", bus.ex_rd_addr, m.rd);
      chk("ex_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, {m.rw, m.mr, m.mw});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_imm = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0;
    bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_rd_addr = 0;
    bus.id_alu_op = 0; bus.id_funct3 = 0; bus.id_funct7_bit5 = 0;
    bus.id_use_pc = 0; bus.id_use_imm = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.ex_ready = 1; flush = 0;
    mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic uimm, input logic mr);
    bus.id_valid = 1; bus.id_pc = pc; bus.id_imm = imm;
    bus.id_rs1_data = d1; bus.id_rs2_data = d2;
    bus.id_rs1_addr = r1; bus.id_rs2_addr = r2; bus.id_rd_addr = rd;
    bus.id_alu_op = 4'h0; bus.id_funct3 = mr ? 3'b010 : 3'b000; bus.id_funct7_bit5 = 0;
    bus.id_use_pc = 0; bus.id_use_imm = uimm;
    bus.id_reg_write = 1; bus.id_mem_read = mr; bus.id_mem_write = 0;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_id_ready", bus.id_ready, 1);
    chk("rst_ex_pc", bus.ex_pc, 0);
    chk("rst_operand_a", bus.ex_operand_a, 0);
    cmp_en = 1;
    rst_n = 1;
    step();

    // Back-to-back ADDs with EX/MEM forwarding of x1
    offer(32'h100, 0, 5, 7, 5'd10, 5'd11, 5'd1, 0, 0);
    step();
    chk("add1_valid", bus.ex_valid, 1);
    chk("add1_a", bus.ex_operand_a, 5);
    chk("add1_b", bus.ex_operand_b, 7);
    offer(32'h104, 1, 0, 0, 5'd1, 5'd0, 5'd2, 1, 0);
    #1 chk("add2_ready", bus.id_ready, 1);
    step();
    idle();
    mem_fwd_valid = 1; mem_fwd_rd = 5'd1; mem_fwd_data = 12;
    #1;
    chk("add2_valid", bus.ex_valid, 1);
    chk("add2_a_fwd", bus.ex_operand_a, 12);
    chk("add2_b_imm", bus.ex_operand_b, 1);
    step();

    // Load-use: LW x3 then ADD x4 = x3 + x0
    idle();
    offer(32'h200, 4, 32'h1000, 0, 5'd2, 5'd0, 5'd3, 1, 1);
    step();
    offer(32'h204, 0, 0, 0, 5'd3, 5'd0, 5'd4, 0, 0);
    #1 chk("lu_stall", bus.id_ready, 0);
    step();
    #1;
    chk("lu_bubble_valid", bus.ex_valid, 0);
    chk("lu_bubble_ready", bus.id_ready, 1);
    step();
    idle();
    wb_fwd_valid = 1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'hCAFE0000;
    #1;
    chk("lu_add_valid", bus.ex_valid, 1);
    chk("lu_add_a", bus.ex_operand_a, 32'hCAFE0000);
    step();

    // Hold for 3 cycles; WB writes x5 during the second
    idle();
    offer(32'h300, 0, 32'h9, 32'h11, 5'd9, 5'd5, 5'd7, 0, 0);
    step();
    idle(); bus.ex_ready = 0;
    #1 chk("hold_b_initial", bus.ex_operand_b, 32'h11);
    step();
    wb_fwd_valid = 1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h55;
    #1 chk("hold_b_wb", bus.ex_operand_b, 32'h55);
    step();
    wb_fwd_valid = 0; wb_fwd_data = 0;
    #1 chk("hold_b_kept", bus.ex_operand_b, 32'h55);
    step();
    bus.ex_ready = 1;
    #1;
    chk("hold_release_valid", bus.ex_valid, 1);
    chk("hold_release_b", bus.ex_operand_b, 32'h55);
    step();

    // Forwarding priority and x0
    idle();
    offer(32'h400, 0, 32'h1234, 0, 5'd6, 5'd0, 5'd8, 0, 0);
    step();
    idle(); bus.ex_ready = 0;
    mem_fwd_valid = 1; mem_fwd_rd = 5'd6; mem_fwd_data = 32'hAAAA;
    wb_fwd_valid = 1; wb_fwd_rd = 5'd6; wb_fwd_data = 32'hBBBB;
    #1 chk("prio_mem_over_wb", bus.ex_operand_a, 32'hAAAA);
    step();
    mem_fwd_rd = 5'd0; mem_fwd_data = 32'hFFFF;
    wb_fwd_rd = 5'd0; wb_fwd_data = 32'hFFFF;
    #1 chk("x0_not_forwarded", bus.ex_operand_b, 0);
    step();

    // Flush while stalled with a new instruction offered
    idle(); bus.ex_ready = 0; flush = 1;
    offer(32'hDEAD, 0, 0, 0, 5'd1, 5'd2, 5'd3, 0, 0);
    #1 chk("flush_ready", bus.id_ready, 1);
    step();
    idle(); bus.ex_ready = 0;
    #1;
    chk("flush_valid", bus.ex_valid, 0);
    chk("flush_no_dead_pc", (bus.ex_pc == 32'hDEAD), 0);
    step();

    // Async reset mid-stall
    idle();
    offer(32'h500, 32'h77, 32'h3, 32'h4, 5'd1, 5'd2, 5'd3, 1, 0);
    step();
    idle(); bus.ex_ready = 0;
    step();
    #2 rst_n = 0;
    #1;
    chk("arst_valid", bus.ex_valid, 0);
    chk("arst_pc", bus.ex_pc, 0);
    chk("arst_b", bus.ex_operand_b, 0);
    chk("arst_rd", bus.ex_rd_addr, 0);
    chk("arst_ready", bus.id_ready, 1);
    step();
    step();
    rst_n = 1;
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.id_valid = ($urandom_range(0, 3) != 0);
      bus.id_pc = $urandom; bus.id_imm = $urandom;
      bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
      bus.id_rs1_addr = 5'($urandom_range(0, 7));
      bus.id_rs2_addr = 5'($urandom_range(0, 7));
      bus.id_rd_addr = 5'($urandom_range(0, 7));
      bus.id_alu_op = 4'($urandom); bus.id_funct3 = 3'($urandom);
      bus.id_funct7_bit5 = 1'($urandom);
      bus.id_use_pc = 1'($urandom); bus.id_use_imm = 1'($urandom);
      bus.id_reg_write = 1'($urandom);
      bus.id_mem_read = ($urandom_range(0, 2) == 0);
      bus.id_mem_write = 1'($urandom);
      bus.ex_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      mem_fwd_valid = 1'($urandom); mem_fwd_rd = 5'($urandom_range(0, 7));
      mem_fwd_data = $urandom;
      wb_fwd_valid = 1'($urandom); wb_fwd_rd = 5'($urandom_range(0, 7));
      wb_fwd_data = $urandom;
      step();
    end

    idle();
    step();
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
